// File: rtl/ac_motor_dir_sequencer.sv
// Direction sequencer for a three-phase CW/CCW swap stage. It adds a dead time on every stop or
// reversal, a minimum run time before a reversal is accepted, and a latched fault stop.
module ac_motor_dir_sequencer #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned DEAD_CYCLES    = 1000,
    parameter int unsigned MIN_RUN_CYCLES = 5000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_dir_req,
    input  logic       i_fault,
    output logic       o_cw,
    output logic       o_ccw,
    output logic       o_busy,
    output logic       o_fault_latched,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRunCw  = 3'd1,
        StRunCcw = 3'd2,
        StDead   = 3'd3,
        StFault  = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] DeadLoad = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MinRun   = CNT_W'(MIN_RUN_CYCLES);
    localparam logic [CNT_W-1:0] MinRunM1 = CNT_W'(MIN_RUN_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] w_run_cnt_next;
    logic [CNT_W-1:0] r_dead_cnt;
    logic [CNT_W-1:0] w_dead_cnt_next;
    logic             w_run_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_run_cnt  <= '0;
            r_dead_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_run_cnt  <= w_run_cnt_next;
            r_dead_cnt <= w_dead_cnt_next;
        end
    end

    assign w_run_ok = (r_run_cnt >= MinRunM1);

    always_comb begin
        w_state_next = r_state;
        if (i_fault) begin
            w_state_next = StFault;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_enable) w_state_next = i_dir_req ? StRunCw : StRunCcw;
                end
                StRunCw: begin
                    if (!i_enable || (!i_dir_req && w_run_ok)) w_state_next = StDead;
                end
                StRunCcw: begin
                    if (!i_enable || (i_dir_req && w_run_ok)) w_state_next = StDead;
                end
                StDead: begin
                    if (r_dead_cnt == '0) begin
                        if (!i_enable)     w_state_next = StIdle;
                        else if (i_dir_req) w_state_next = StRunCw;
                        else               w_state_next = StRunCcw;
                    end
                end
                StFault: begin
                    if (!i_enable) w_state_next = StIdle;
                end
                default: w_state_next = StFault;
            endcase
        end
    end

    // Counters restart whenever their state is entered afresh, including DEAD -> RUN.
    always_comb begin
        w_run_cnt_next  = '0;
        w_dead_cnt_next = '0;
        if ((w_state_next == StRunCw) || (w_state_next == StRunCcw)) begin
            if (w_state_next == r_state) begin
                w_run_cnt_next = (r_run_cnt < MinRun) ? r_run_cnt + 1'b1 : r_run_cnt;
            end
        end
        if (w_state_next == StDead) begin
            w_dead_cnt_next = (r_state == StDead) ? r_dead_cnt - 1'b1 : DeadLoad;
        end
    end

    always_comb begin
        o_cw            = (r_state == StRunCw);
        o_ccw           = (r_state == StRunCcw);
        o_busy          = (r_state == StDead);
        o_fault_latched = (r_state == StFault);
        o_state         = r_state;
    end

endmodule

// File: tb/tb_ac_motor_dir_sequencer.sv
// Directed bench for ac_motor_dir_sequencer with DEAD_CYCLES=4 and MIN_RUN_CYCLES=8.
module tb_ac_motor_dir_sequencer;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CW    = 3'd1;
    localparam logic [2:0] S_CCW   = 3'd2;
    localparam logic [2:0] S_DEAD  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       fault;
    logic       cw;
    logic       ccw;
    logic       busy;
    logic       fault_latched;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    ac_motor_dir_sequencer #(
        .CNT_W(16),
        .DEAD_CYCLES(4),
        .MIN_RUN_CYCLES(8)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_enable(en),
        .i_dir_req(dir),
        .i_fault(fault),
        .o_cw(cw),
        .o_ccw(ccw),
        .o_busy(busy),
        .o_fault_latched(fault_latched),
        .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {cw, ccw, busy, fault_latched, state} for a given state code.
    function automatic logic [6:0] exp_vec(input logic [2:0] s);
        return {s == S_CW, s == S_CCW, s == S_DEAD, s == S_FAULT, s};
    endfunction

    task automatic chk(input string tag, input logic [2:0] s);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {cw, ccw, busy, fault_latched, state};
        exp = exp_vec(s);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {cw,ccw,busy,flt,state}=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        dir   = 1'b0;
        fault = 1'b0;

        // Reset then start CW
        repeat (3) begin
            tick();
            chk("reset", S_IDLE);
        end
        rst_n = 1'b1;
        en    = 1'b1;
        dir   = 1'b1;
        tick();
        chk("start_cw", S_CW);

        // Reversal after minimum run
        repeat (9) tick();
        chk("run_cw_long", S_CW);
        dir = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("rev_dead", S_DEAD);
            tick();
        end
        chk("rev_ccw", S_CCW);

        // Stop from RUN_CCW
        en = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("stop_dead", S_DEAD);
            tick();
        end
        chk("stop_idle", S_IDLE);

        // Early reversal blocked until run counter reaches 7
        en  = 1'b1;
        dir = 1'b1;
        tick();
        chk("early_start", S_CW);
        tick();
        tick();
        dir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("early_hold", S_CW);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("early_dead", S_DEAD);
            tick();
        end
        chk("early_ccw", S_CCW);

        // Reversal cancelled during DEAD returns to the original direction
        repeat (8) tick();
        chk("cancel_pre", S_CCW);
        dir = 1'b1;
        tick();
        chk("cancel_dead0", S_DEAD);
        dir = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("cancel_dead", S_DEAD);
            tick();
        end
        chk("cancel_back_ccw", S_CCW);

        // Fault latch and re-arm
        fault = 1'b1;
        tick();
        chk("fault_entry", S_FAULT);
        fault = 1'b0;
        tick();
        chk("fault_hold_en", S_FAULT);
        tick();
        chk("fault_hold_en2", S_FAULT);
        en = 1'b0;
        tick();
        chk("fault_rearm", S_IDLE);

        // Stop before min run, then fault on the edge DEAD expires
        en  = 1'b1;
        dir = 1'b1;
        tick();
        chk("stop_early_run", S_CW);
        en = 1'b0;
        tick();
        chk("stop_early_dead", S_DEAD);
        repeat (3) tick();
        chk("dead_last", S_DEAD);
        fault = 1'b1;
        en    = 1'b1;
        tick();
        chk("fault_at_expiry", S_FAULT);
        fault = 1'b0;
        en    = 1'b0;
        tick();
        chk("fault_clear_idle", S_IDLE);

        // ENABLE falls on the same edge a reversal qualifies
        en  = 1'b1;
        dir = 1'b1;
        tick();
        chk("sim_run", S_CW);
        repeat (8) tick();
        en  = 1'b0;
        dir = 1'b0;
        tick();
        chk("sim_dead", S_DEAD);
        repeat (3) tick();
        chk("sim_dead_last", S_DEAD);
        tick();
        chk("sim_idle", S_IDLE);

        // Asynchronous reset mid-run
        en  = 1'b1;
        dir = 1'b0;
        tick();
        chk("arst_run", S_CCW);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_async", S_IDLE);
        tick();
        chk("arst_held", S_IDLE);
        rst_n = 1'b1;
        en    = 1'b0;
        tick();
        chk("arst_release", S_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
